// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM stream reader and its skid buffer.
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = 2;

  // Room exists when buffered words plus the word in flight, minus the word
  // leaving this cycle, still leave a free slot for the next read.
  function automatic logic room_to_issue(
    input logic [SKID_CNT_W-1:0] count,
    input logic                  inflight,
    input logic                  pop
  );
    logic [SKID_CNT_W:0] occ;
    occ = {1'b0, count} + {{SKID_CNT_W{1'b0}}, inflight} - {{SKID_CNT_W{1'b0}}, pop};
    return occ < (SKID_CNT_W+1)'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Two-entry register skid buffer of {data, last} beats; push and pop may coincide.
module bram_skid_fifo
  import bram_stream_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_W-1:0]     i_push_data,
  input  logic                  i_push_last,
  input  logic                  i_pop,
  output logic [SKID_CNT_W-1:0] o_count,
  output logic [DATA_W-1:0]     o_head_data,
  output logic                  o_head_last
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t                 r_mem [SKID_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [SKID_CNT_W-1:0] r_count;
  beat_t                 w_head;

  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (i_push && (r_wr_ptr == 1'(gi))) begin
        r_mem[gi] <= '{data: i_push_data, last: i_push_last};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_head_data = w_head.data;
  assign o_head_last = w_head.last;

endmodule

// File: rtl/bram_stream_reader.sv
// Turns a (base, length) command into BRAM reads and a valid/ready word stream with last.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [ADDR_W:0]   cmd_len_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              busy_o
);

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W-1:0]     r_addr_hold;
  logic [ADDR_W:0]       r_remain;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_final_issue;
  logic [SKID_CNT_W-1:0] w_count;
  logic                  w_head_last;

  assign w_accept      = cmd_valid_i & cmd_ready_o;
  assign w_pop         = m_valid_o & m_ready_i;
  assign w_issue       = (r_state == READ) && (r_remain != '0)
                         && room_to_issue(w_count, r_inflight, w_pop);
  assign w_final_issue = w_issue && (r_remain == (ADDR_W+1)'(1));

  // The BRAM samples the address every cycle; between issues it sees the last one.
  assign rd_addr_o = w_issue ? r_addr : r_addr_hold;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && (cmd_len_i != '0)) w_state_next = READ;
      READ:    if (w_final_issue) w_state_next = DRAIN;
      DRAIN:   if (!r_inflight && (w_count == '0) && !w_pop) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    if (r_state == IDLE) begin
      cmd_ready_o = 1'b1;
      busy_o      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr          <= '0;
      r_addr_hold     <= '0;
      r_remain        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_final_issue;
      if (w_accept) begin
        r_addr   <= cmd_base_i;
        r_remain <= cmd_len_i;
      end else if (w_issue) begin
        r_addr      <= r_addr + 1'b1;
        r_remain    <= r_remain - 1'b1;
        r_addr_hold <= r_addr;
      end
    end
  end

  bram_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (rd_data_i),
    .i_push_last (r_inflight_last),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head_data (m_data_o),
    .o_head_last (w_head_last)
  );

  assign m_valid_o = (w_count != '0);
  assign m_last_o  = m_valid_o & w_head_last;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural 1-cycle-latency BRAM.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [11:0] cmd_base_i;
  logic [12:0] cmd_len_i;
  logic [11:0] rd_addr_o;
  logic [31:0] rd_data_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] m_data_o;
  logic        m_last_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bram_stream_reader #(.DATA_W(32), .ADDR_W(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_base_i  (cmd_base_i),
    .cmd_len_i   (cmd_len_i),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .busy_o      (busy_o)
  );

  // Memory contents encode the address so every word identifies where it came from.
  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return 32'hDA7A_0000 | {20'h0, a};
  endfunction

  always @(posedge clk) rd_data_i <= mem_word(rd_addr_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [11:0] base, input logic [12:0] len);
    check("cmd_ready_before_cmd", {31'b0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_base_i  = base;
    cmd_len_i   = len;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    $display("[TB] cmd base=%03h len=%0d", base, len);
  endtask

  // mode 0: ready high; mode 1: ready toggles; mode 2: ready low 10 cycles after first valid
  task automatic recv_burst(input logic [11:0] base, input int len, input int n_take,
                            input int mode, input string name);
    int          got = 0;
    int          cyc = 0;
    int          first_pop = -1;
    int          last_pop = -1;
    int          since_valid = -1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [11:0] a;
    while (got < n_take && cyc < 300) begin
      if (m_valid_o && since_valid < 0) since_valid = 0;
      case (mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = (cyc % 2 == 0);
        default: m_ready_i = (since_valid >= 10);
      endcase
      if (prev_stall) begin
        check({name, "_stall_valid"}, {31'b0, m_valid_o}, 32'd1);
        check({name, "_stall_data"}, m_data_o, prev_data);
        check({name, "_stall_last"}, {31'b0, m_last_o}, {31'b0, prev_last});
      end
      if (mode == 2 && since_valid == 9)
        check({name, "_buffered"}, {30'b0, dut.u_fifo.r_count}, 32'd2);
      if (mode == 2 && since_valid >= 0)
        check({name, "_no_overflow"}, {31'b0, (dut.u_fifo.r_count <= 2'd2)}, 32'd1);
      if (m_valid_o && m_ready_i) begin
        a = base + 12'(got);
        check({name, "_data"}, m_data_o, mem_word(a));
        check({name, "_last"}, {31'b0, m_last_o}, {31'b0, (got == len - 1)});
        $display("[TB] %s word %0d addr=%03h data=%08h last=%0b", name, got, a, m_data_o, m_last_o);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        got++;
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      prev_last  = m_last_o;
      if (since_valid >= 0) since_valid++;
      @(negedge clk);
      cyc++;
    end
    check({name, "_count"}, got, n_take);
    if (mode != 1 && got == n_take)
      check({name, "_back_to_back"}, last_pop - first_pop, n_take - 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!cmd_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, {31'b0, cmd_ready_o}, 32'd1);
    check({name, "_idle_valid"}, {31'b0, m_valid_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_base_i  = '0;
    cmd_len_i   = '0;
    m_ready_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    check("rst_m_valid", {31'b0, m_valid_o}, 32'd0);
    check("rst_m_last", {31'b0, m_last_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_rd_addr", {20'b0, rd_addr_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: latency and sustained throughput
    m_ready_i = 1'b1;
    do_cmd(12'h010, 13'd4);
    check("t1_rd_addr_base", {20'b0, rd_addr_o}, 32'h010);
    check("t1_valid_c1", {31'b0, m_valid_o}, 32'd0);
    check("t1_busy", {31'b0, busy_o}, 32'd1);
    @(negedge clk);
    check("t1_valid_c2", {31'b0, m_valid_o}, 32'd0);
    @(negedge clk);
    check("t1_valid_c3", {31'b0, m_valid_o}, 32'd1);
    recv_burst(12'h010, 4, 4, 0, "t1");
    wait_idle("t1");

    // Test 2: toggling ready
    do_cmd(12'h020, 13'd8);
    recv_burst(12'h020, 8, 8, 1, "t2");
    wait_idle("t2");

    // Test 3: address wrap
    do_cmd(12'hFFE, 13'd4);
    check("t3_rd_addr_base", {20'b0, rd_addr_o}, 32'hFFE);
    recv_burst(12'hFFE, 4, 4, 0, "t3");
    wait_idle("t3");

    // Test 4: zero-length command then single word
    do_cmd(12'h055, 13'd0);
    for (int i = 0; i < 5; i++) begin
      check("t4_busy", {31'b0, busy_o}, 32'd0);
      check("t4_no_valid", {31'b0, m_valid_o}, 32'd0);
      @(negedge clk);
    end
    do_cmd(12'h123, 13'd1);
    recv_burst(12'h123, 1, 1, 0, "t4b");
    wait_idle("t4b");

    // Test 5: long stall then release
    m_ready_i = 1'b0;
    do_cmd(12'h100, 13'd16);
    recv_burst(12'h100, 16, 16, 2, "t5");
    wait_idle("t5");

    // Test 6: reset in the middle of a transfer
    m_ready_i = 1'b1;
    do_cmd(12'h040, 13'd10);
    recv_burst(12'h040, 10, 3, 0, "t6a");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_valid", {31'b0, m_valid_o}, 32'd0);
    check("t6_rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    check("t6_rst_busy", {31'b0, busy_o}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_quiet", {31'b0, m_valid_o}, 32'd0);
    end
    do_cmd(12'h300, 13'd3);
    recv_burst(12'h300, 3, 3, 0, "t6b");
    wait_idle("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
